// File: rtl/barrido_display.sv
// barrido_display: 4-digit 7-segment scan controller with blanking guard.
// Ports: i_Clk, i_Rst (sync, high), i_En, i_Dato[3:0] in; o_Sel[1:0],
// o_Anodos[3:0], o_Segmentos[6:0] {g..a}, o_Fin_Cuadro out.
// Optional macro ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module barrido_display #(
  parameter int P_DWELL      = 1000,
  parameter int P_GUARD      = 16,
  parameter int P_ANODO_BAJO = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic [3:0] i_Dato,
  output logic [1:0] o_Sel,
  output logic [3:0] o_Anodos,
  output logic [6:0] o_Segmentos,
  output logic       o_Fin_Cuadro
);

  localparam int CW = $clog2(P_DWELL);
  localparam logic [CW-1:0] LAST  = CW'(P_DWELL - 1);
  localparam logic [CW-1:0] GUARD = CW'(P_GUARD);
  localparam logic [3:0] OFF =
    (P_ANODO_BAJO != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    an_nx;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_smp;
  logic          wrap;
  logic          muestra;

  function automatic logic [6:0] deco(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = 7'h00;
    unique case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap    = i_En && (cnt == LAST);
    muestra = i_En && (cnt == '0);
    cnt_nx  = cnt;
    sel_nx  = o_Sel;
    if (i_En) begin
      cnt_nx = wrap ? '0 : cnt + CW'(1);
      if (wrap)
        sel_nx = o_Sel - 2'd1;
    end
    // Anodes are registered from the next count so
    // they line up with cnt in the same cycle.
    an_nx = OFF;
    if (i_En && (cnt_nx >= GUARD))
      an_nx = OFF ^ (4'b0001 << sel_nx);
    seg_dec = deco(i_Dato);
  end

`ifdef ZERO_BLANK_EN
  logic flag;
  logic flag_nx;

  always_comb begin
    seg_smp = seg_dec;
    flag_nx = flag;
    if (wrap && (o_Sel == 2'd0)) begin
      flag_nx = 1'b1;
    end else if (muestra && (o_Sel != 2'd0)) begin
      if (flag && (i_Dato == 4'h0))
        seg_smp = 7'h00;
      else
        flag_nx = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      flag <= 1'b1;
    else
      flag <= flag_nx;
  end
`else
  always_comb seg_smp = seg_dec;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt          <= '0;
      o_Sel        <= 2'd3;
      o_Anodos     <= OFF;
      o_Segmentos  <= 7'h00;
      o_Fin_Cuadro <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      o_Sel        <= sel_nx;
      o_Anodos     <= an_nx;
      if (muestra)
        o_Segmentos <= seg_smp;
      o_Fin_Cuadro <= wrap && (o_Sel == 2'd0);
    end
  end

endmodule

// File: tb/tb_barrido_display.sv
// tb_barrido_display: scoreboard bench for barrido_display.
// Checks reset, frame scan, blanking, enable gap, mid-scan reset.
module tb_barrido_display;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fin;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] val [4];
  logic [3:0] dato;
  logic [3:0] dato_h;
  logic [1:0] sel;
  logic [1:0] sel_h;
  logic [3:0] an;
  logic [3:0] an_h;
  logic [6:0] seg;
  logic [6:0] seg_h;
  logic       fin;
  logic       fin_h;

  exp_t q [$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

`ifdef ZERO_BLANK_EN
  localparam logic [6:0] Z3 = 7'h00;
  localparam logic [6:0] Z2 = 7'h00;
`else
  localparam logic [6:0] Z3 = 7'h3F;
  localparam logic [6:0] Z2 = 7'h3F;
`endif

  barrido_display #(
    .P_DWELL(8), .P_GUARD(2), .P_ANODO_BAJO(1)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_En(en),
    .i_Dato(dato), .o_Sel(sel), .o_Anodos(an),
    .o_Segmentos(seg), .o_Fin_Cuadro(fin)
  );

  barrido_display #(
    .P_DWELL(8), .P_GUARD(2), .P_ANODO_BAJO(0)
  ) dut_h (
    .i_Clk(clk), .i_Rst(rst), .i_En(en),
    .i_Dato(dato_h), .o_Sel(sel_h), .o_Anodos(an_h),
    .o_Segmentos(seg_h), .o_Fin_Cuadro(fin_h)
  );

  always_comb begin
    dato   = val[sel];
    dato_h = val[sel_h];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (sel === e.sel) else begin
        errors++;
        $error("FAIL sel: got %h expected %h", sel, e.sel);
      end
      checks++;
      assert (an === e.an) else begin
        errors++;
        $error("FAIL anodos: got %h expected %h", an, e.an);
      end
      checks++;
      assert (an_h === (e.an ^ 4'hF)) else begin
        errors++;
        $error("FAIL anodos_h: got %h expected %h",
               an_h, e.an ^ 4'hF);
      end
      checks++;
      assert (seg === e.seg) else begin
        errors++;
        $error("FAIL seg: got %h expected %h", seg, e.seg);
      end
      checks++;
      assert (fin === e.fin) else begin
        errors++;
        $error("FAIL fin: got %b expected %b", fin, e.fin);
      end
    end
  end

  task automatic push_cycle(
    input logic [1:0] s,
    input logic [3:0] a,
    input logic [6:0] sg,
    input logic       f
  );
    exp_t x;
    @(posedge clk);
    #1;
    x.sel = s;
    x.an  = a;
    x.seg = sg;
    x.fin = f;
    q.push_back(x);
  endtask

  task automatic phase(
    input logic [1:0] s,
    input int         lo,
    input int         hi,
    input logic [3:0] pat,
    input logic [6:0] sp,
    input logic [6:0] sn,
    input logic       f0
  );
    for (int c = lo; c <= hi; c++)
      push_cycle(s,
                 (c < 2) ? 4'hF : pat,
                 (c == 0) ? sp : sn,
                 (c == 0) ? f0 : 1'b0);
  endtask

  task automatic set_vals(
    input logic [3:0] d3,
    input logic [3:0] d2,
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    val[3] = d3;
    val[2] = d2;
    val[1] = d1;
    val[0] = d0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    set_vals(4'h1, 4'h2, 4'h3, 4'h4);
    repeat (3) push_cycle(2'd3, 4'hF, 7'h00, 1'b0);
    rst = 1'b0;

    phase(2'd3, 1, 7, 4'h7, 7'h00, 7'h06, 1'b0);
    phase(2'd2, 0, 7, 4'hB, 7'h06, 7'h5B, 1'b0);
    phase(2'd1, 0, 7, 4'hD, 7'h5B, 7'h4F, 1'b0);
    phase(2'd0, 0, 7, 4'hE, 7'h4F, 7'h66, 1'b0);
    phase(2'd3, 0, 0, 4'h7, 7'h66, 7'h00, 1'b1);
    set_vals(4'h0, 4'h0, 4'h7, 4'h0);

    phase(2'd3, 1, 7, 4'h7, 7'h66, Z3, 1'b0);
    phase(2'd2, 0, 7, 4'hB, Z3, Z2, 1'b0);
    phase(2'd1, 0, 7, 4'hD, Z2, 7'h07, 1'b0);
    phase(2'd0, 0, 7, 4'hE, 7'h07, 7'h3F, 1'b0);
    phase(2'd3, 0, 0, 4'h7, 7'h3F, 7'h00, 1'b1);
    set_vals(4'h1, 4'h2, 4'h3, 4'h4);

    phase(2'd3, 1, 7, 4'h7, 7'h3F, 7'h06, 1'b0);
    phase(2'd2, 0, 4, 4'hB, 7'h06, 7'h5B, 1'b0);
    en = 1'b0;
    repeat (5) push_cycle(2'd2, 4'hF, 7'h5B, 1'b0);
    en = 1'b1;
    phase(2'd2, 5, 7, 4'hB, 7'h5B, 7'h5B, 1'b0);
    phase(2'd1, 0, 5, 4'hD, 7'h5B, 7'h4F, 1'b0);

    rst = 1'b1;
    push_cycle(2'd3, 4'hF, 7'h00, 1'b0);
    rst = 1'b0;
    phase(2'd3, 1, 7, 4'h7, 7'h00, 7'h06, 1'b0);
    phase(2'd2, 0, 0, 4'hB, 7'h06, 7'h00, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
